// File: rtl/gravsim_pkg.sv
// rtl/gravsim_pkg.sv - shared types and register layout for the ball hit tester
//
// Contents:
//   COORD_W / RAD_W    coordinate and radius widths
//   *_LSB / EN_BIT     bit positions of the fields in a ball register word
//   STATUS_ADDR        word address of the read-only status register
//   ball_t             one ball: enable, radius, centre y, centre x
//   pack_ball()        ball_t -> 32-bit register word (reserved bits read 0)
package gravsim_pkg;

  localparam int COORD_W = 10;
  localparam int RAD_W   = 6;

  localparam int X_LSB  = 0;
  localparam int Y_LSB  = 10;
  localparam int R_LSB  = 20;
  localparam int EN_BIT = 31;

  localparam logic [3:0] STATUS_ADDR = 4'd8;

  typedef struct packed {
    logic               en;
    logic [RAD_W-1:0]   r;
    logic [COORD_W-1:0] y;
    logic [COORD_W-1:0] x;
  } ball_t;

  function automatic logic [31:0] pack_ball(input ball_t b);
    logic [31:0] w;
    w = '0;
    w[X_LSB +: COORD_W] = b.x;
    w[Y_LSB +: COORD_W] = b.y;
    w[R_LSB +: RAD_W]   = b.r;
    w[EN_BIT]           = b.en;
    return w;
  endfunction

endpackage

// File: rtl/ball_dist_check.sv
// rtl/ball_dist_check.sv - two-stage distance test of one pixel against one ball
//
// Ports:
//   clk    in   clock
//   reset  in   synchronous active-high reset
//   px     in   pixel column
//   py     in   pixel row
//   ball   in   active-bank entry for this ball (sampled each stage)
//   hit    out  registered: pixel lies inside this enabled ball
//
// Stage 1 registers the signed offsets and the squared radius; stage 2
// squares and sums the offsets and compares. The enable is taken at stage 2
// so each stage sees the bank as it is in its own cycle.
module ball_dist_check
  import gravsim_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [COORD_W-1:0] px,
  input  logic [COORD_W-1:0] py,
  input  ball_t              ball,
  output logic               hit
);

  localparam int D2_W = 2 * COORD_W + 2;

  logic signed [COORD_W:0]   dx_q;
  logic signed [COORD_W:0]   dy_q;
  logic [2*RAD_W-1:0]        rr_q;
  logic [2*RAD_W-1:0]        r_ext;
  logic [2*RAD_W-1:0]        rr_d;

  assign r_ext = {{RAD_W{1'b0}}, ball.r};
  assign rr_d  = r_ext * r_ext;

  // Stage 1: offsets carry one extra bit so 0 - 1023 is representable.
  always_ff @(posedge clk) begin
    if (reset) begin
      dx_q <= '0;
      dy_q <= '0;
      rr_q <= '0;
    end else begin
      dx_q <= $signed({1'b0, px}) - $signed({1'b0, ball.x});
      dy_q <= $signed({1'b0, py}) - $signed({1'b0, ball.y});
      rr_q <= rr_d;
    end
  end

  // Stage 2: sign-extend before squaring so the low D2_W product bits are
  // the exact (non-negative) square.
  logic signed [D2_W-1:0] dx_ext;
  logic signed [D2_W-1:0] dy_ext;
  logic [D2_W-1:0]        dx_sq;
  logic [D2_W-1:0]        dy_sq;
  logic [D2_W-1:0]        d2;

  assign dx_ext = {{(COORD_W + 1){dx_q[COORD_W]}}, dx_q};
  assign dy_ext = {{(COORD_W + 1){dy_q[COORD_W]}}, dy_q};
  assign dx_sq  = dx_ext * dx_ext;
  assign dy_sq  = dy_ext * dy_ext;
  assign d2     = dx_sq + dy_sq;

  always_ff @(posedge clk) begin
    if (reset) begin
      hit <= 1'b0;
    end else begin
      hit <= ball.en & (d2 <= {{(D2_W - 2*RAD_W){1'b0}}, rr_q});
    end
  end

endmodule

// File: rtl/ball_hit_tester.sv
// rtl/ball_hit_tester.sv - Avalon-MM ball register file with per-pixel hit test
//
// Ports:
//   Clk            in   system clock
//   Reset          in   synchronous active-high reset
//   avs_address    in   word address: 0..NUM_BALLS-1 balls, 8 status
//   avs_chipselect in   chip select
//   avs_write      in   write strobe
//   avs_writedata  in   write data
//   avs_read       in   read strobe
//   avs_readdata   out  registered read data, latency 1, held between reads
//   VGA_VS         in   vertical sync, active low; falling edge swaps banks
//   DrawX / DrawY  in   pixel coordinate, low COORD_W bits used
//   is_ball        out  pixel inside an enabled ball (3 cycles after DrawX/Y)
//   ballID         out  lowest-index ball hit, 0 when none
//
// Software writes the pending bank; the pixel path reads the active bank,
// which is refreshed from pending on each VS falling edge so a frame never
// shows a half-updated set of balls.
module ball_hit_tester
  import gravsim_pkg::*;
#(
  parameter  int NUM_BALLS = 4,
  localparam int ID_W      = $clog2(NUM_BALLS)
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic [3:0]      avs_address,
  input  logic            avs_chipselect,
  input  logic            avs_write,
  input  logic [31:0]     avs_writedata,
  input  logic            avs_read,
  output logic [31:0]     avs_readdata,
  input  logic            VGA_VS,
  input  logic [31:0]     DrawX,
  input  logic [31:0]     DrawY,
  output logic            is_ball,
  output logic [ID_W-1:0] ballID
);

  ball_t pending [0:NUM_BALLS-1];
  ball_t active  [0:NUM_BALLS-1];

  logic        vs_q;
  logic        swap;
  logic [15:0] frame_count;
  logic        dirty;

  logic            wr_en;
  logic            rd_en;
  logic            addr_is_ball;
  logic [ID_W-1:0] addr_idx;
  ball_t           wr_ball;
  logic [31:0]     rd_mux;

  assign wr_en        = avs_chipselect & avs_write;
  assign rd_en        = avs_chipselect & avs_read;
  assign addr_is_ball = avs_address < 4'(NUM_BALLS);
  assign addr_idx     = avs_address[ID_W-1:0];
  assign swap         = vs_q & ~VGA_VS;

  assign wr_ball.x  = avs_writedata[X_LSB +: COORD_W];
  assign wr_ball.y  = avs_writedata[Y_LSB +: COORD_W];
  assign wr_ball.r  = avs_writedata[R_LSB +: RAD_W];
  assign wr_ball.en = avs_writedata[EN_BIT];

  // Reserved data bits and the unused upper coordinate bits are dropped.
  logic unused_bits;
  assign unused_bits = ^{DrawX[31:COORD_W], DrawY[31:COORD_W],
                         avs_writedata[EN_BIT-1:R_LSB+RAD_W]};

  always_comb begin
    rd_mux = '0;
    if (addr_is_ball) begin
      rd_mux = pack_ball(pending[addr_idx]);
    end else if (avs_address == STATUS_ADDR) begin
      rd_mux = {frame_count, 15'd0, dirty};
    end
  end

  // The swap copies pending as it was before this edge, so a write landing
  // on the swap cycle reaches active only on the following frame and keeps
  // dirty set.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < NUM_BALLS; i++) begin
        pending[i] <= '0;
        active[i]  <= '0;
      end
      vs_q         <= 1'b1;
      frame_count  <= '0;
      dirty        <= 1'b0;
      avs_readdata <= '0;
    end else begin
      vs_q <= VGA_VS;
      if (swap) begin
        for (int i = 0; i < NUM_BALLS; i++) begin
          active[i] <= pending[i];
        end
        frame_count <= frame_count + 16'd1;
      end
      if (wr_en && addr_is_ball) begin
        pending[addr_idx] <= wr_ball;
        dirty             <= 1'b1;
      end else if (swap) begin
        dirty <= 1'b0;
      end
      if (rd_en) begin
        avs_readdata <= rd_mux;
      end
    end
  end

  // Stages 1 and 2, one checker per ball.
  logic [NUM_BALLS-1:0] hit;

  for (genvar g = 0; g < NUM_BALLS; g++) begin : g_ball
    ball_dist_check u_check (
      .clk   (Clk),
      .reset (Reset),
      .px    (DrawX[COORD_W-1:0]),
      .py    (DrawY[COORD_W-1:0]),
      .ball  (active[g]),
      .hit   (hit[g])
    );
  end

  // Stage 3: priority encode, lowest index wins.
  logic [ID_W-1:0] id_next;

  always_comb begin
    id_next = '0;
    for (int i = NUM_BALLS - 1; i >= 0; i--) begin
      if (hit[i]) begin
        id_next = ID_W'(i);
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      is_ball <= 1'b0;
      ballID  <= '0;
    end else begin
      is_ball <= |hit;
      ballID  <= id_next;
    end
  end

endmodule
